bcd_multi_counter: RTL and testbench
====================================

# bcd_multi_counter

Parametrised multi-digit BCD counter that cascades DIGITS decade stages (each 0–9) into one decimal count. It supports count enable, synchronous parallel load with digit validation, and a registered one-cycle wrap pulse for chaining or event flagging. Optional down-counting is compiled in by macro. It serves as the general counting primitive for display, timer and event-tally paths, replacing fixed single-decade counters.

## Interface
- DIGITS, 4, number of BCD decades (1–8); count width = 4*DIGITS
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  count one step this cycle when high
- up  in  1  direction: 1 = increment, 0 = decrement (ignored unless BCD_CNT_DOWN_EN)
- load  in  1  synchronous parallel load strobe
- load_value  in  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
- count  out  4*DIGITS  current BCD value, digit 0 = least significant
- wrap  out  1  one-cycle pulse: count rolled over past its end value
- load_err  out  1  one-cycle pulse: last load contained a digit > 9

## Operation
- Priority per clock edge: reset > load > enable > hold.
- Load: each digit of load_value is written to count. Any digit > 9 is written as 0 instead, and load_err = 1 on the next cycle. Valid digits load unchanged. wrap = 0 on a load cycle.
- Increment: digit 0 adds 1. A digit at 9 becomes 0 and carries into the next digit. Count 99…9 becomes 00…0 and sets wrap = 1.
- Decrement (macro only): digit 0 subtracts 1. A digit at 0 becomes 9 and borrows from the next digit. Count 00…0 becomes 99…9 and sets wrap = 1.
- enable = 0 with load = 0: count holds, and wrap and load_err are 0.
- Count never holds a digit > 9 after reset or after any operation.
- wrap and load_err are registered pulses. Each is high for exactly one cycle per event. Back-to-back events give back-to-back pulses.

## Timing
- Reset values: count = 0, wrap = 0, load_err = 0. They take effect immediately on reset assertion, independent of clock.
- Reset asserted mid-count clears all state at once. The first count step after release happens on the first clock edge with enable = 1 and reset = 0.
- Latency: count reflects load or enable one clock after the edge that samples it.
- wrap is asserted in the same cycle that count first shows the wrapped value (00…0 up, 99…9 down).
- load and enable asserted together: the load wins and no count step occurs.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- BCD_CNT_DOWN_EN defined: the up port selects the direction each cycle. Decrement and borrow logic are built. Direction may change on any cycle with no dead cycle.
- BCD_CNT_DOWN_EN undefined: the counter is increment-only. The up port remains on the interface but is ignored, and no decrement logic is synthesised.

## Test plan
- Reset: assert reset asynchronously mid-cycle while count = 0x0375 (DIGITS = 4) -> count = 0x0000, wrap = 0, load_err = 0 before the next edge.
- Cascade: load 0x0999, enable for 1 cycle -> count = 0x1000, wrap = 0. Load 0x9999, enable for 1 cycle -> count = 0x0000, wrap = 1 for exactly one cycle.
- Invalid load: load 0x3A7F -> count = 0x3070, load_err = 1 for one cycle. Load 0x1234 -> load_err = 0.
- Priority: load = 1 and enable = 1 with load_value 0x0500 -> count = 0x0500, not 0x0501. Enable = 0 for 5 cycles -> count holds at 0x0500.
- Down (macro defined): load 0x1000, up = 0, enable for 1 cycle -> 0x0999. Load 0x0000, then 1 step -> 0x9999 with wrap = 1. With the macro undefined, the same stimulus -> 0x1001.
- Long run: DIGITS = 2, enable held for 250 cycles from reset -> count = 0x50, with exactly 2 wrap pulses at cycles 100 and 200.

Source files
------------

// File: rtl/bcd_multi_counter_if.sv
// Bus bundle for bcd_multi_counter: count controls in, BCD count and event pulses out.
// The master drives the controls and the slave (the counter) drives the results.
`timescale 1ns/1ps

interface bcd_multi_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  enable;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output enable, up, load, load_value,
        input  count, wrap, load_err
    );

    modport slave (
        input  enable, up, load, load_value,
        output count, wrap, load_err
    );
endinterface

// File: rtl/bcd_multi_counter.sv
// Cascaded DIGITS-decade BCD counter with enable, validated parallel load and
// registered wrap / load_err pulses.
// Optional macro BCD_CNT_DOWN_EN: builds decrement/borrow logic and lets the
// 'up' input select direction per cycle. Without it the counter only increments.
`timescale 1ns/1ps

module bcd_multi_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    bcd_multi_counter_if.slave     cnt_if
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] inc_val;
    logic         inc_wrap;
    logic [W-1:0] load_val;
    logic         load_bad;

    // Increment ripple: 9s roll to 0 and pass the carry up; carry out of the top is a wrap.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        inc_val = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        inc_wrap = carry;
    end

`ifdef BCD_CNT_DOWN_EN
    logic [W-1:0] dec_val;
    logic         dec_wrap;

    // Decrement ripple: 0s roll to 9 and pass the borrow up; borrow out of the top is a wrap.
    always_comb begin
        logic borrow;
        borrow  = 1'b1;
        dec_val = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
        dec_wrap = borrow;
    end
`else
    // Direction input exists on the bus but has no effect in this build.
    logic unused_up;
    assign unused_up = cnt_if.up;
`endif

    // Load sanitiser: non-decimal digits are forced to 0 and flagged.
    always_comb begin
        load_val = cnt_if.load_value;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_if.load_value[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd0;
                load_bad           = 1'b1;
            end
        end
    end

    // Next state: load beats enable beats hold; pulses default low.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (cnt_if.load) begin
            count_d    = load_val;
            load_err_d = load_bad;
        end else if (cnt_if.enable) begin
`ifdef BCD_CNT_DOWN_EN
            if (cnt_if.up) begin
                count_d = inc_val;
                wrap_d  = inc_wrap;
            end else begin
                count_d = dec_val;
                wrap_d  = dec_wrap;
            end
`else
            count_d = inc_val;
            wrap_d  = inc_wrap;
`endif
        end
    end

    // State and output flops with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt_if.count    = count_q;
    assign cnt_if.wrap     = wrap_q;
    assign cnt_if.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Scoreboard bench for bcd_multi_counter: stimulus pushes expected results computed
// from a decimal-integer model, a monitor pops and compares after every clock edge.
`timescale 1ns/1ps

module tb_bcd_multi_counter;
    localparam int MOD = 10000;
`ifdef BCD_CNT_DOWN_EN
    localparam bit DOWN_BUILT = 1'b1;
`else
    localparam bit DOWN_BUILT = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] count;
        logic        wrap;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_multi_counter_if #(.DIGITS(4)) cif ();
    bcd_multi_counter_if #(.DIGITS(2)) cif2 ();

    bcd_multi_counter #(.DIGITS(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .cnt_if (cif)
    );

    bcd_multi_counter #(.DIGITS(2)) dut2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .cnt_if (cif2)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_val = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model works on the plain decimal value.
    task automatic step(input bit en, input bit up, input bit ld, input logic [15:0] lv);
        exp_t e;
        int   v;
        int   p;
        int   d;
        bit   go_up;
        @(negedge clk);
        cif.enable     = en;
        cif.up         = up;
        cif.load       = ld;
        cif.load_value = lv;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        go_up  = up || !DOWN_BUILT;
        if (ld) begin
            v = 0;
            p = 1;
            for (int i = 0; i < 4; i++) begin
                d = int'(lv[4*i +: 4]);
                if (d > 9) begin
                    d     = 0;
                    e.err = 1'b1;
                end
                v += d * p;
                p *= 10;
            end
            model_val = v;
        end else if (en) begin
            if (go_up) begin
                model_val = (model_val + 1) % MOD;
                e.wrap    = (model_val == 0);
            end else if (model_val == 0) begin
                model_val = MOD - 1;
                e.wrap    = 1'b1;
            end else begin
                model_val = model_val - 1;
            end
        end
        e.count = to_bcd(model_val);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation just after the edge that produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", 32'(cif.count), 32'(e.count));
                check("wrap", 32'(cif.wrap), 32'(e.wrap));
                check("load_err", 32'(cif.load_err), 32'(e.err));
            end
        end
    end

    initial begin
        int          wraps;
        int          wrap_at[2];
        int          t;
        logic [15:0] lv;

        rst             = 1'b1;
        cif.enable      = 1'b0;
        cif.up          = 1'b1;
        cif.load        = 1'b0;
        cif.load_value  = '0;
        cif2.enable     = 1'b0;
        cif2.up         = 1'b1;
        cif2.load       = 1'b0;
        cif2.load_value = '0;
        #12;
        check("reset count", 32'(cif.count), 32'h0);
        check("reset wrap", 32'(cif.wrap), 32'h0);
        check("reset load_err", 32'(cif.load_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Cascade and top wrap
        step(0, 1, 1, 16'h0999);
        step(1, 1, 0, 16'h0);
        step(0, 1, 1, 16'h9999);
        step(1, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        // Invalid digits on load
        step(0, 1, 1, 16'h3A7F);
        step(0, 1, 0, 16'h0);
        step(0, 1, 1, 16'h1234);
        // Load beats enable, then hold
        step(1, 1, 1, 16'h0500);
        repeat (5) step(0, 1, 0, 16'h0);
        // Down-count (or ignored direction in the up-only build)
        step(0, 0, 1, 16'h1000);
        step(1, 0, 0, 16'h0);
        step(0, 0, 1, 16'h0000);
        step(1, 0, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);

        // Randomised mix; some loads land near the ends to provoke wraps.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       lv = 16'($urandom);
                1:       lv = to_bcd(9995 + int'($urandom_range(0, 4)));
                2:       lv = to_bcd(int'($urandom_range(0, 4)));
                default: lv = to_bcd(int'($urandom_range(0, 9999)));
            endcase
            step(($urandom % 4) != 0, $urandom_range(0, 1) == 1, ($urandom % 8) == 0, lv);
        end

        // Asynchronous reset in the middle of a cycle
        step(0, 1, 1, 16'h0375);
        step(0, 1, 0, 16'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst count", 32'(cif.count), 32'h0);
        check("async rst wrap", 32'(cif.wrap), 32'h0);
        check("async rst load_err", 32'(cif.load_err), 32'h0);
        model_val = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);

        // Drain the scoreboard with a bounded wait
        t = 0;
        while (exp_q.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        // Long run on the two-decade counter
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        cif2.enable = 1'b1;
        wraps       = 0;
        wrap_at[0]  = 0;
        wrap_at[1]  = 0;
        for (int k = 1; k <= 250; k++) begin
            @(posedge clk);
            #1;
            if (cif2.wrap) begin
                if (wraps < 2) wrap_at[wraps] = k;
                wraps++;
            end
            if (k == 100) check("long count@100", 32'(cif2.count), 32'h00);
        end
        cif2.enable = 1'b0;
        check("long count@250", 32'(cif2.count), 32'h50);
        check("long wrap pulses", 32'(wraps), 32'd2);
        check("long first wrap", 32'(wrap_at[0]), 32'd100);
        check("long second wrap", 32'(wrap_at[1]), 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
